// File: rtl/coherency_req_arbiter.sv
// Round-robin merge of NUM_CORES L1 coherency request channels into one registered, source-tagged stream.
// Define COH_ARB_LINE_LOCK_EN to block requests whose cache line is already outstanding.
module coherency_req_arbiter #(
  parameter int NUM_CORES        = 4,
  parameter int ADDR_WIDTH       = 32,
  parameter int REQ_TYPE_WIDTH   = 3,
  parameter int CORE_ID_WIDTH    = $clog2(NUM_CORES),
  parameter int LINE_OFFSET_BITS = 6,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_CORES-1:0]                req_valid_i,
  output logic [NUM_CORES-1:0]                req_ready_o,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [NUM_CORES*REQ_TYPE_WIDTH-1:0] req_type_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [ADDR_WIDTH-1:0]               out_addr_o,
  output logic [REQ_TYPE_WIDTH-1:0]           out_type_o,
  output logic [CORE_ID_WIDTH-1:0]            out_source_o,
  input  logic                                done_valid_i,
  input  logic [ADDR_WIDTH-1:0]               done_addr_i
);

  logic                     load_en;
  logic                     found;
  logic                     grant;
  logic [CORE_ID_WIDTH-1:0] rr_ptr;
  logic [CORE_ID_WIDTH-1:0] winner;
  logic [NUM_CORES-1:0]     eligible;

  assign load_en = !out_valid_o || out_ready_i;

`ifdef COH_ARB_LINE_LOCK_EN
  localparam int LINE_WIDTH = ADDR_WIDTH - LINE_OFFSET_BITS;

  logic [MAX_OUTSTANDING-1:0] tbl_valid;
  logic [LINE_WIDTH-1:0]      tbl_line [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] tbl_keep;
  logic [MAX_OUTSTANDING-1:0] alloc_slot;
  logic                       alloc_found;
  logic [NUM_CORES-1:0]       blocked;
  logic [LINE_WIDTH-1:0]      done_line;
  logic [LINE_WIDTH-1:0]      out_line;
  logic                       out_pop;
  logic                       unused_done_offset;

  assign done_line          = done_addr_i[ADDR_WIDTH-1:LINE_OFFSET_BITS];
  assign out_line           = out_addr_o[ADDR_WIDTH-1:LINE_OFFSET_BITS];
  assign out_pop            = out_valid_o && out_ready_i;
  assign unused_done_offset = ^done_addr_i[LINE_OFFSET_BITS-1:0];

  always_comb begin
    blocked = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if ((&tbl_valid) ||
          (out_valid_o && req_addr_i[i*ADDR_WIDTH+LINE_OFFSET_BITS +: LINE_WIDTH] == out_line))
        blocked[i] = 1'b1;
      for (int unsigned j = 0; j < MAX_OUTSTANDING; j++) begin
        if (tbl_valid[j] && tbl_line[j] == req_addr_i[i*ADDR_WIDTH+LINE_OFFSET_BITS +: LINE_WIDTH])
          blocked[i] = 1'b1;
      end
    end
  end

  // The allocation slot is chosen after this cycle's free, so a pop into a
  // full table that coincides with a done reuses the freed entry.
  always_comb begin
    tbl_keep    = '0;
    alloc_slot  = '0;
    alloc_found = 1'b0;
    for (int unsigned j = 0; j < MAX_OUTSTANDING; j++)
      tbl_keep[j] = tbl_valid[j] && !(done_valid_i && tbl_line[j] == done_line);
    for (int unsigned j = 0; j < MAX_OUTSTANDING; j++) begin
      if (out_pop && !tbl_keep[j] && !alloc_found) begin
        alloc_slot[j] = 1'b1;
        alloc_found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid <= '0;
      for (int unsigned j = 0; j < MAX_OUTSTANDING; j++) tbl_line[j] <= '0;
    end else begin
      tbl_valid <= tbl_keep | alloc_slot;
      for (int unsigned j = 0; j < MAX_OUTSTANDING; j++)
        if (alloc_slot[j]) tbl_line[j] <= out_line;
    end
  end

  assign eligible = req_valid_i & ~blocked;
`else
  logic unused_done;

  assign unused_done = ^{done_valid_i, done_addr_i};
  assign eligible    = req_valid_i;
`endif

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (!found && eligible[rr_ptr + CORE_ID_WIDTH'(k)]) begin
        found  = 1'b1;
        winner = rr_ptr + CORE_ID_WIDTH'(k);
      end
    end
  end

  assign grant = found && load_en && rst_n;

  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o  <= 1'b0;
      out_addr_o   <= '0;
      out_type_o   <= '0;
      out_source_o <= '0;
      rr_ptr       <= '0;
    end else if (grant) begin
      out_valid_o  <= 1'b1;
      out_addr_o   <= req_addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
      out_type_o   <= req_type_i[winner*REQ_TYPE_WIDTH +: REQ_TYPE_WIDTH];
      out_source_o <= winner;
      rr_ptr       <= winner + 1'b1;
    end else if (out_ready_i) begin
      out_valid_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_coherency_req_arbiter.sv
// Self-checking bench for coherency_req_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model (line-lock checks active when COH_ARB_LINE_LOCK_EN is defined).
module tb_coherency_req_arbiter;
  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int TW  = 3;
  localparam int IW  = 2;
  localparam int LOB = 6;
  localparam int MO  = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [N*AW-1:0] req_addr_i;
  logic [N*TW-1:0] req_type_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [AW-1:0]   out_addr_o;
  logic [TW-1:0]   out_type_o;
  logic [IW-1:0]   out_source_o;
  logic            done_valid_i;
  logic [AW-1:0]   done_addr_i;

  coherency_req_arbiter #(
    .NUM_CORES(N), .ADDR_WIDTH(AW), .REQ_TYPE_WIDTH(TW), .CORE_ID_WIDTH(IW),
    .LINE_OFFSET_BITS(LOB), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_type_i(req_type_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_addr_o(out_addr_o), .out_type_o(out_type_o), .out_source_o(out_source_o),
    .done_valid_i(done_valid_i), .done_addr_i(done_addr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the output register contents, the rotation pointer and a list of outstanding lines.
  logic          m_valid;
  logic [AW-1:0] m_addr;
  logic [TW-1:0] m_type;
  int            m_src;
  int            m_ptr;
  int unsigned   m_lines[$];
  int            last_win;
  logic [AW-1:0] rnd_a;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned line_of(input logic [AW-1:0] a);
    return a >> LOB;
  endfunction

  function automatic bit line_busy(input logic [AW-1:0] a);
`ifdef COH_ARB_LINE_LOCK_EN
    if (m_valid && line_of(m_addr) == line_of(a)) return 1'b1;
    foreach (m_lines[k]) if (m_lines[k] == line_of(a)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int exp_winner();
    int c;
    if (!rst_n) return -1;
    if (m_valid && !out_ready_i) return -1;
`ifdef COH_ARB_LINE_LOCK_EN
    if (m_lines.size() >= MO) return -1;
`endif
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (req_valid_i[c] && !line_busy(req_addr_i[c*AW +: AW])) return c;
    end
    return -1;
  endfunction

  task automatic set_req(input int c, input logic v, input logic [AW-1:0] a, input logic [TW-1:0] t);
    req_valid_i[c]          = v;
    req_addr_i[c*AW +: AW]  = a;
    req_type_i[c*TW +: TW]  = t;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_addr = '0; m_type = '0; m_src = 0; m_ptr = 0;
    m_lines.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid_i = '0; done_valid_i = 1'b0; out_ready_i = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: called just after a negedge with inputs already driven.
  task automatic tick();
    int w;
    logic [N-1:0] exp_rdy;
    #1;
    w = exp_winner();
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("ready", 64'(req_ready_o), 64'(exp_rdy));
    check("out_valid", 64'(out_valid_o), 64'(m_valid));
    check("out_addr", 64'(out_addr_o), 64'(m_addr));
    check("out_type", 64'(out_type_o), 64'(m_type));
    check("out_source", 64'(out_source_o), 64'(m_src));
    last_win = w;
    @(posedge clk);
`ifdef COH_ARB_LINE_LOCK_EN
    if (done_valid_i)
      for (int k = m_lines.size() - 1; k >= 0; k--)
        if (m_lines[k] == line_of(done_addr_i)) m_lines.delete(k);
    if (m_valid && out_ready_i) m_lines.push_back(line_of(m_addr));
`endif
    if (w >= 0) begin
      m_valid = 1'b1;
      m_addr  = req_addr_i[w*AW +: AW];
      m_type  = req_type_i[w*TW +: TW];
      m_src   = w;
      m_ptr   = (w + 1) % N;
    end else if (out_ready_i) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] rand_addr();
`ifdef COH_ARB_LINE_LOCK_EN
    return AW'($urandom & 32'h0000_03FF);
`else
    return AW'($urandom);
`endif
  endfunction

  initial begin
    req_addr_i = '0; req_type_i = '0; done_addr_i = '0; last_win = -1;
    rst_n = 1'b0;
    req_valid_i = '1;
    #2;
    check("reset_ready", 64'(req_ready_o), 64'h0);
    do_reset();

    // Single core request
    set_req(2, 1'b1, 32'h0000_1040, 3'd3);
    #1 check("single_ready", 64'(req_ready_o), 64'b0100);
    tick();
    check("single_valid", 64'(out_valid_o), 64'h1);
    check("single_addr", 64'(out_addr_o), 64'h1040);
    check("single_type", 64'(out_type_o), 64'h3);
    check("single_src", 64'(out_source_o), 64'h2);
    req_valid_i = '0;
    tick();

    // All cores valid: strict rotation with no bubbles
    do_reset();
    for (int c = 0; c < N; c++) set_req(c, 1'b1, 32'h0000_4000 + 32'(c) * 32'h100, TW'(c));
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rot_valid", 64'(out_valid_o), 64'h1);
      check("rot_src", 64'(out_source_o), 64'(k % N));
    end

    // Backpressure: hold output while out_ready_i is low
    do_reset();
    set_req(1, 1'b1, 32'h0000_2000, 3'd1);
    tick();
    set_req(0, 1'b1, 32'h0000_2080, 3'd2);
    set_req(1, 1'b1, 32'h0000_2040, 3'd4);
    set_req(2, 1'b1, 32'h0000_20C0, 3'd5);
    out_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_ready", 64'(req_ready_o), 64'h0);
      check("stall_src", 64'(out_source_o), 64'h1);
      check("stall_addr", 64'(out_addr_o), 64'h2000);
      tick();
    end
    out_ready_i = 1'b1;
    #1 check("unstall_ready", 64'(req_ready_o), 64'b0100);
    tick();
    check("unstall_src", 64'(out_source_o), 64'h2);
    check("unstall_addr", 64'(out_addr_o), 64'h20C0);

    // Pointer wrap from 3 back to 0
    do_reset();
    set_req(2, 1'b1, 32'h0000_3000, 3'd0);
    tick();
    req_valid_i = '0;
    set_req(0, 1'b1, 32'h0000_3100, 3'd6);
    set_req(3, 1'b1, 32'h0000_3300, 3'd7);
    tick();
    check("wrap_first", 64'(out_source_o), 64'h3);
    tick();
    check("wrap_second", 64'(out_source_o), 64'h0);

    // Asynchronous reset while a request is held
    req_valid_i = '0;
    set_req(1, 1'b1, 32'h0000_5000, 3'd2);
    out_ready_i = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    model_reset();
    set_req(3, 1'b1, 32'h0000_5300, 3'd3);
    #1;
    check("arst_valid", 64'(out_valid_o), 64'h0);
    check("arst_ready", 64'(req_ready_o), 64'h0);
    out_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_src", 64'(out_source_o), 64'h1);
    req_valid_i = '0;
    tick();

`ifdef COH_ARB_LINE_LOCK_EN
    // Line lock: same-line requests wait for done, distinct lines proceed, full table stalls all
    do_reset();
    set_req(0, 1'b1, 32'h0000_0100, 3'd1);
    tick();
    req_valid_i = '0;
    set_req(1, 1'b1, 32'h0000_013C, 3'd2);
    set_req(2, 1'b1, 32'h0000_0140, 3'd3);
    #1 check("lock_other_line", 64'(req_ready_o), 64'b0100);
    tick();
    req_valid_i[2] = 1'b0;
    #1 check("lock_same_line", 64'(req_ready_o), 64'h0);
    tick();
    done_valid_i = 1'b1; done_addr_i = 32'h0000_0100;
    #1 check("lock_done_cycle", 64'(req_ready_o), 64'h0);
    tick();
    done_valid_i = 1'b0;
    #1 check("lock_released", 64'(req_ready_o), 64'b0010);
    tick();
    req_valid_i = '0;
    set_req(0, 1'b1, 32'h0000_0200, 3'd4);
    set_req(3, 1'b1, 32'h0000_0300, 3'd5);
    tick();
    tick();
    req_valid_i = '0;
    tick();
    set_req(2, 1'b1, 32'h0000_0400, 3'd6);
    for (int k = 0; k < 2; k++) begin
      #1 check("lock_full", 64'(req_ready_o), 64'h0);
      tick();
    end
    done_valid_i = 1'b1; done_addr_i = 32'h0000_0140;
    tick();
    done_valid_i = 1'b0;
    #1 check("lock_full_freed", 64'(req_ready_o), 64'b0100);
    tick();
    req_valid_i = '0;
    tick();
`endif

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (req_valid_i[c] && last_win != c) begin
          if ($urandom_range(0, 7) == 0) req_valid_i[c] = 1'b0;
        end else begin
          rnd_a = rand_addr();
          set_req(c, 1'($urandom_range(0, 1)), rnd_a, TW'($urandom_range(0, 7)));
        end
      end
      out_ready_i  = ($urandom_range(0, 3) != 0);
      done_valid_i = 1'b0;
      done_addr_i  = AW'($urandom);
`ifdef COH_ARB_LINE_LOCK_EN
      if (m_lines.size() > 0 && $urandom_range(0, 3) == 0) begin
        done_valid_i = 1'b1;
        done_addr_i  = AW'((m_lines[$urandom_range(0, m_lines.size() - 1)] << LOB) | $urandom_range(0, 63));
      end
      if (m_lines.size() >= MO && !done_valid_i) out_ready_i = 1'b0;
`else
      done_valid_i = 1'($urandom_range(0, 1));
`endif
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
